// File: rtl/pc_seq_ras.sv
// PC sequencer: holds the architectural PC, issues valid/ready fetch requests,
// resolves retire-time branches and trap redirects, and scores jalr returns on a RAS.
module pc_seq_ras #(
    parameter int              XLEN      = 64,
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   RESET_VEC = 32'h8000_0000,
    parameter int              RAS_DEPTH = 4,
    parameter int              CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [AW-1:0]     req_pc_o,
    input  logic              ex_valid_i,
    input  logic [2:0]        ex_op_i,
    input  logic              ex_zero_i,
    input  logic              ex_less_i,
    input  logic [XLEN-1:0]   ex_src1_i,
    input  logic [XLEN-1:0]   ex_imm_i,
    input  logic              ex_link_i,
    input  logic              ex_ret_i,
    input  logic              trap_valid_i,
    input  logic [AW-1:0]     trap_pc_i,
    output logic              flush_o,
    output logic [AW-1:0]     pc_o,
    output logic [CNT_W-1:0]  ras_hits_o,
    output logic [CNT_W-1:0]  ras_miss_o
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic {S_FETCH, S_EXEC} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d, pend_pc_q, pend_pc_d;
    logic               pend_q, pend_d, flush_q, flush_d;
    logic [AW-1:0]      ras_q [RAS_DEPTH];
    logic [PW-1:0]      sp_q, sp_d, sp_pop, ras_widx;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_pop;
    logic [CNT_W-1:0]   hits_q, hits_d, miss_q, miss_d;
    logic [AW-1:0]      next_pc, link_addr, taken_pc, jalr_pc, top_entry;
    logic               retire, do_pop, do_push, ras_we;
    logic               unused_upper;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign req_valid_o  = (state_q == S_FETCH) && !rst;
    assign req_pc_o     = pc_q;
    assign pc_o         = pc_q;
    assign flush_o      = flush_q;
    assign ras_hits_o   = hits_q;
    assign ras_miss_o   = miss_q;

    assign link_addr    = pc_q + AW'(4);
    assign taken_pc     = pc_q + ex_imm_i[AW-1:0];
    assign jalr_pc      = (ex_src1_i[AW-1:0] + ex_imm_i[AW-1:0]) & ~AW'(1);
    assign top_entry    = ras_q[sp_q - PW'(1)];
    // Only the low AW bits of the operands can affect a PC.
    assign unused_upper = ^{ex_src1_i[XLEN-1:AW], ex_imm_i[XLEN-1:AW]};

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        next_pc = pc_q;
        case (ex_op_i)
            3'b000:  next_pc = link_addr;
            3'b001:  next_pc = taken_pc;
            3'b010:  next_pc = jalr_pc;
            3'b100:  next_pc = ex_zero_i  ? taken_pc : link_addr;
            3'b101:  next_pc = !ex_zero_i ? taken_pc : link_addr;
            3'b110:  next_pc = ex_less_i  ? taken_pc : link_addr;
            3'b111:  next_pc = !ex_less_i ? taken_pc : link_addr;
            default: next_pc = pc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        flush_d   = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (req_valid_o && req_ready_i) begin
                    // A redirect seen while this request was outstanding kills its instruction.
                    if (trap_valid_i || pend_q) begin
                        pc_d    = trap_valid_i ? trap_pc_i : pend_pc_q;
                        pend_d  = 1'b0;
                        flush_d = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                    end
                end else if (trap_valid_i) begin
                    if (req_valid_o) begin
                        pend_d    = 1'b1;
                        pend_pc_d = trap_pc_i;
                    end else begin
                        pc_d = trap_pc_i;
                    end
                end
            end
            S_EXEC: begin
                if (trap_valid_i) begin
                    pc_d    = trap_pc_i;
                    state_d = S_FETCH;
                end else if (ex_valid_i) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Pop first, then push on top of the popped position; link+ret thus replaces the top.
    always_comb begin
        do_pop  = retire && ex_ret_i;
        do_push = retire && ex_link_i;
        sp_pop  = sp_q;
        cnt_pop = cnt_q;
        hits_d  = hits_q;
        miss_d  = miss_q;
        if (do_pop) begin
            if (cnt_q == '0) begin
                miss_d = sat_inc(miss_q);
            end else begin
                sp_pop  = sp_q - PW'(1);
                cnt_pop = cnt_q - CW'(1);
                if (top_entry == next_pc) hits_d = sat_inc(hits_q);
                else                      miss_d = sat_inc(miss_q);
            end
        end
        sp_d     = sp_pop;
        cnt_d    = cnt_pop;
        ras_we   = do_push;
        ras_widx = sp_pop;
        if (do_push) begin
            sp_d  = sp_pop + PW'(1);
            cnt_d = (cnt_pop == CW'(RAS_DEPTH)) ? cnt_pop : cnt_pop + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_VEC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            flush_q   <= 1'b0;
            sp_q      <= '0;
            cnt_q     <= '0;
            hits_q    <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            flush_q   <= flush_d;
            sp_q      <= sp_d;
            cnt_q     <= cnt_d;
            hits_q    <= hits_d;
            miss_q    <= miss_d;
        end
    end

    // NOTE: the stack array is not reset; a zero count makes its contents unreachable.
    always_ff @(posedge clk) begin
        if (ras_we && !rst) ras_q[ras_widx] <= link_addr;
    end

endmodule
